// File: rtl/srs_rotation_kicker.sv
// -----------------------------------------------------------------------------
// srs_rotation_kicker
//
// Resolves one SRS rotation request for the active tetromino. Walks the
// wall-kick candidates one at a time, handing each to the board collision
// checker over a valid/response handshake. Reports the first candidate that
// fits, or failure once every allowed test has collided.
//
// Piece encoding on req_idx:
//   0 = I, 1 = O, 2 = T, 3 = S, 4 = Z, 5 = J, 6 = L.
//   I uses its own kick table, O only ever tries test 0, and every other
//   code uses the JLSTZ table.
//
// Coordinates are two's complement COORD_W-bit values. Kicks wrap modulo
// 2^COORD_W with no saturation, because bounds checking is the checker's job.
//
// Ports
//   clk, reset_n              clock, synchronous active-low reset
//   req_valid / req_ready     request handshake (ready only in IDLE)
//   req_dir                   0 = clockwise, 1 = counter-clockwise
//   req_rotation, req_idx     current rotation 0..3 and piece type
//   req_x, req_y              current piece origin
//   chk_valid                 one-cycle pulse presenting a candidate
//   chk_x, chk_y, chk_rotation
//                             candidate, held from ISSUE through WAIT
//   chk_resp_valid, chk_collide
//                             checker answer (collide sampled with valid)
//   abort                     cancel the in-flight request (ISSUE/WAIT)
//   done                      one-cycle completion pulse
//   success                   a candidate fit, held until the next accept
//   new_x, new_y, new_rotation
//                             accepted placement, or the original on failure
//   kick_step                 accepted test index, or the number of tests tried
//
// States
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | ready for a request
//   ISSUE   | chk_valid pulse for the current candidate
//   WAIT    | candidate held, waiting for the checker answer
//   DONE    | done pulse, result registers valid
// -----------------------------------------------------------------------------
module srs_rotation_kicker #(
  parameter int COORD_W   = 5,
  parameter int NUM_TESTS = 5,
  parameter int Y_DOWN    = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_dir,
  input  logic [1:0]         req_rotation,
  input  logic [2:0]         req_idx,
  input  logic [COORD_W-1:0] req_x,
  input  logic [COORD_W-1:0] req_y,
  output logic               chk_valid,
  output logic [COORD_W-1:0] chk_x,
  output logic [COORD_W-1:0] chk_y,
  output logic [1:0]         chk_rotation,
  input  logic               chk_resp_valid,
  input  logic               chk_collide,
  input  logic               abort,
  output logic               done,
  output logic               success,
  output logic [COORD_W-1:0] new_x,
  output logic [COORD_W-1:0] new_y,
  output logic [1:0]         new_rotation,
  output logic [2:0]         kick_step
);

  localparam logic [2:0] PIECE_I = 3'd0;
  localparam logic [2:0] PIECE_O = 3'd1;

  // 3-bit signed kick components
  localparam logic [2:0] M2 = 3'b110;
  localparam logic [2:0] M1 = 3'b111;
  localparam logic [2:0] Z0 = 3'b000;
  localparam logic [2:0] P1 = 3'b001;
  localparam logic [2:0] P2 = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [COORD_W-1:0] org_x, org_y;
  logic [1:0]         rot_q;
  logic               dir_q;
  logic               is_i_q;
  logic [2:0]         limit_q;
  logic [2:0]         step_q;

  logic [2:0]         step_inc;
  logic               last_test;
  logic [5:0]         kick_nxt;
  logic [2:0]         dy_eff;
  logic [COORD_W-1:0] cand_x_nxt, cand_y_nxt;

  // Clockwise kick {dx, dy} (+x right, +y up) for leaving rotation r at test t.
  function automatic logic [5:0] kick_cw(input logic is_i, input logic [1:0] r,
                                         input logic [2:0] t);
    logic [5:0] k;
    k = {Z0, Z0};
    if (is_i) begin
      case ({r, t})
        {2'd0, 3'd1}: k = {M2, Z0};
        {2'd0, 3'd2}: k = {P1, Z0};
        {2'd0, 3'd3}: k = {M2, M1};
        {2'd0, 3'd4}: k = {P1, P2};
        {2'd1, 3'd1}: k = {M1, Z0};
        {2'd1, 3'd2}: k = {P2, Z0};
        {2'd1, 3'd3}: k = {M1, P2};
        {2'd1, 3'd4}: k = {P2, M1};
        {2'd2, 3'd1}: k = {P2, Z0};
        {2'd2, 3'd2}: k = {M1, Z0};
        {2'd2, 3'd3}: k = {P2, P1};
        {2'd2, 3'd4}: k = {M1, M2};
        {2'd3, 3'd1}: k = {P1, Z0};
        {2'd3, 3'd2}: k = {M2, Z0};
        {2'd3, 3'd3}: k = {P1, M2};
        {2'd3, 3'd4}: k = {M2, P1};
        default:      k = {Z0, Z0};
      endcase
    end else begin
      case ({r, t})
        {2'd0, 3'd1}: k = {M1, Z0};
        {2'd0, 3'd2}: k = {M1, P1};
        {2'd0, 3'd3}: k = {Z0, M2};
        {2'd0, 3'd4}: k = {M1, M2};
        {2'd1, 3'd1}: k = {P1, Z0};
        {2'd1, 3'd2}: k = {P1, M1};
        {2'd1, 3'd3}: k = {Z0, P2};
        {2'd1, 3'd4}: k = {P1, P2};
        {2'd2, 3'd1}: k = {P1, Z0};
        {2'd2, 3'd2}: k = {P1, P1};
        {2'd2, 3'd3}: k = {Z0, M2};
        {2'd2, 3'd4}: k = {P1, M2};
        {2'd3, 3'd1}: k = {M1, Z0};
        {2'd3, 3'd2}: k = {M1, M1};
        {2'd3, 3'd3}: k = {Z0, P2};
        {2'd3, 3'd4}: k = {M1, P2};
        default:      k = {Z0, Z0};
      endcase
    end
    return k;
  endfunction

  // CCW from r reuses the CW entry for r-1 with both components negated.
  function automatic logic [5:0] kick(input logic ccw, input logic is_i,
                                      input logic [1:0] r, input logic [2:0] t);
    logic [5:0] e;
    if (ccw) begin
      e = kick_cw(is_i, r - 2'd1, t);
      return {3'd0 - e[5:3], 3'd0 - e[2:0]};
    end
    return kick_cw(is_i, r, t);
  endfunction

  function automatic logic [COORD_W-1:0] sext3(input logic [2:0] v);
    return {{(COORD_W-3){v[2]}}, v};
  endfunction

  // Candidate for the test after the current one, loaded on a collision.
  always_comb begin
    step_inc   = step_q + 3'd1;
    last_test  = (step_inc == limit_q);
    kick_nxt   = kick(dir_q, is_i_q, rot_q, step_inc);
    dy_eff     = (Y_DOWN != 0) ? (3'd0 - kick_nxt[2:0]) : kick_nxt[2:0];
    cand_x_nxt = org_x + sext3(kick_nxt[5:3]);
    cand_y_nxt = org_y + sext3(dy_eff);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    chk_valid = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        chk_valid = 1'b1;
        state_nxt = abort ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (chk_resp_valid) begin
          if (!chk_collide || last_test) state_nxt = S_DONE;
          else                           state_nxt = S_ISSUE;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      org_x        <= '0;
      org_y        <= '0;
      rot_q        <= '0;
      dir_q        <= 1'b0;
      is_i_q       <= 1'b0;
      limit_q      <= '0;
      step_q       <= '0;
      chk_x        <= '0;
      chk_y        <= '0;
      chk_rotation <= '0;
      success      <= 1'b0;
      new_x        <= '0;
      new_y        <= '0;
      new_rotation <= '0;
      kick_step    <= '0;
    end else if (state == S_IDLE && req_valid) begin
      org_x        <= req_x;
      org_y        <= req_y;
      rot_q        <= req_rotation;
      dir_q        <= req_dir;
      is_i_q       <= (req_idx == PIECE_I);
      limit_q      <= (req_idx == PIECE_O) ? 3'd1 : 3'(NUM_TESTS);
      step_q       <= '0;
      // Test 0 is the unshifted origin for every piece.
      chk_x        <= req_x;
      chk_y        <= req_y;
      chk_rotation <= req_dir ? (req_rotation - 2'd1) : (req_rotation + 2'd1);
      success      <= 1'b0;
    end else if (state == S_WAIT && !abort && chk_resp_valid) begin
      if (!chk_collide) begin
        success      <= 1'b1;
        new_x        <= chk_x;
        new_y        <= chk_y;
        new_rotation <= chk_rotation;
        kick_step    <= step_q;
      end else begin
        step_q <= step_inc;
        if (last_test) begin
          success      <= 1'b0;
          new_x        <= org_x;
          new_y        <= org_y;
          new_rotation <= rot_q;
          kick_step    <= step_inc;
        end else begin
          chk_x <= cand_x_nxt;
          chk_y <= cand_y_nxt;
        end
      end
    end
  end

endmodule
